// File: rtl/instruction_ci_mc.sv
// Multi-cycle executor for a subset of RV compressed instructions (c.li, c.addi, c.lui,
// c.addi16sp, c.slli, c.lwsp) with a simple request/ack RAM port for the stack load.
module instruction_ci_mc #(
    parameter int XLEN   = 32,
    parameter int RAM_AW = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic [15:0]       iIR,
    output logic [4:0]        oRS1,
    input  logic [XLEN-1:0]   iRS1,
    output logic [4:0]        oRD,
    output logic              oRD_WE,
    output logic [XLEN-1:0]   oRD_DATA,
    output logic              oDONE,
    output logic              oILLEGAL,
    output logic              oMISALIGNED,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic [RAM_AW-1:0] oRAM_ADDR,
    input  logic [31:0]       iRAM_DATA,
    input  logic              iRAM_ACK
);

    typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_DONE} state_t;

    state_t              r_state;
    logic [4:0]          r_rd;
    logic                r_we;
    logic [XLEN-1:0]     r_data;
    logic                r_done;
    logic                r_illegal;
    logic                r_misaligned;
    logic                r_ram_ce;
    logic                r_ram_rd;
    logic [RAM_AW-1:0]   r_ram_addr;

    logic [4:0]          w_rd;
    logic [5:0]          w_imm6;
    logic [9:0]          w_imm16sp;
    logic [7:0]          w_lw_off;
    logic [RAM_AW+1:0]   w_addr;
    logic                w_is_lwsp;
    logic                w_we;
    logic                w_ill;
    logic                w_mis;
    logic                w_load;
    logic [XLEN-1:0]     w_val;
    logic [XLEN-1:0]     w_data;

    function automatic logic signed [XLEN-1:0] sext6(input logic [5:0] v);
        return XLEN'(signed'(v));
    endfunction

    function automatic logic signed [XLEN-1:0] sext10(input logic [9:0] v);
        return XLEN'(signed'(v));
    endfunction

    function automatic logic signed [XLEN-1:0] sext18(input logic [17:0] v);
        return XLEN'(signed'(v));
    endfunction

    function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'(signed'(v));
    endfunction

    assign w_rd      = iIR[11:7];
    assign w_imm6    = {iIR[12], iIR[6:2]};
    assign w_imm16sp = {iIR[12], iIR[4:3], iIR[5], iIR[2], iIR[6], 4'b0000};
    assign w_lw_off  = {iIR[3:2], iIR[12], iIR[6:4], 2'b00};
    assign w_is_lwsp = (iIR[1:0] == 2'b10) && (iIR[15:13] == 3'b010);
    // Only the low RAM_AW+2 address bits matter: alignment plus the truncated word address.
    assign w_addr    = iRS1[RAM_AW+1:0] + (RAM_AW+2)'(w_lw_off);

    assign oRS1 = w_is_lwsp ? 5'd2 : w_rd;

    always_comb begin
        w_we   = 1'b0;
        w_val  = '0;
        w_ill  = 1'b0;
        w_mis  = 1'b0;
        w_load = 1'b0;
        case ({iIR[1:0], iIR[15:13]})
            5'b01_010: begin
                w_val = sext6(w_imm6);
                w_we  = (w_rd != 5'd0);
            end
            5'b01_000: begin
                w_val = iRS1 + sext6(w_imm6);
                w_we  = (w_rd != 5'd0) && (w_imm6 != 6'd0);
            end
            5'b01_011: begin
                if (w_rd == 5'd2) begin
                    if (w_imm16sp == 10'd0) begin
                        w_ill = 1'b1;
                    end else begin
                        w_val = iRS1 + sext10(w_imm16sp);
                        w_we  = 1'b1;
                    end
                end else if (w_imm6 == 6'd0) begin
                    w_ill = 1'b1;
                end else begin
                    w_val = sext18({w_imm6, 12'h000});
                    w_we  = (w_rd != 5'd0);
                end
            end
            5'b10_000: begin
                if ((XLEN == 32) && iIR[12]) begin
                    w_ill = 1'b1;
                end else begin
                    w_val = iRS1 << w_imm6;
                    w_we  = (w_rd != 5'd0) && (w_imm6 != 6'd0);
                end
            end
            5'b10_010: begin
                if (w_rd == 5'd0) begin
                    w_ill = 1'b1;
                end else if (w_addr[1:0] != 2'b00) begin
                    w_mis = 1'b1;
                end else begin
                    w_load = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_data = w_we ? w_val : '0;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state      <= S_IDLE;
            r_rd         <= '0;
            r_we         <= 1'b0;
            r_data       <= '0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
            r_misaligned <= 1'b0;
            r_ram_ce     <= 1'b0;
            r_ram_rd     <= 1'b0;
            r_ram_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iVALID) begin
                        r_rd <= w_rd;
                        if (w_load) begin
                            r_ram_ce   <= 1'b1;
                            r_ram_rd   <= 1'b1;
                            r_ram_addr <= w_addr[RAM_AW+1:2];
                            r_state    <= S_MEM_WAIT;
                        end else begin
                            r_done       <= 1'b1;
                            r_we         <= w_we;
                            r_data       <= w_data;
                            r_illegal    <= w_ill;
                            r_misaligned <= w_mis;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    // Wait indefinitely; the request stays asserted and stable until the ack.
                    if (iRAM_ACK) begin
                        r_ram_ce <= 1'b0;
                        r_ram_rd <= 1'b0;
                        r_done   <= 1'b1;
                        r_we     <= 1'b1;
                        r_data   <= sext32(iRAM_DATA);
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done       <= 1'b0;
                    r_we         <= 1'b0;
                    r_data       <= '0;
                    r_illegal    <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oREADY      = (r_state == S_IDLE);
    assign oRD         = r_rd;
    assign oRD_WE      = r_we;
    assign oRD_DATA    = r_data;
    assign oDONE       = r_done;
    assign oILLEGAL    = r_illegal;
    assign oMISALIGNED = r_misaligned;
    assign oRAM_CE     = r_ram_ce;
    assign oRAM_RD     = r_ram_rd;
    assign oRAM_ADDR   = r_ram_addr;

endmodule

// File: doc/instruction_ci_mc.md
INSTRUCTION_CI_MC -- requirements
Module: instruction_ci_mc

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter RAM_AW, default 8, giving the RAM word-address width.
REQ-003 Port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port iRST, input, 1 bit: synchronous, active-high reset.
REQ-005 Port iVALID, input, 1 bit: an instruction is offered on iIR and iRS1.
REQ-006 Port oREADY, output, 1 bit: the block accepts an instruction; a transfer occurs when iVALID and oREADY are both high.
REQ-007 Port iIR, input, 16 bits: compressed instruction.
REQ-008 Port oRS1, output, 5 bits: combinational source index from iIR.
REQ-009 Port iRS1, input, XLEN bits: value of register oRS1.
REQ-010 Port oRD, output, 5 bits: registered destination index.
REQ-011 Port oRD_WE, output, 1 bit: write-enable, valid only with oDONE.
REQ-012 Port oRD_DATA, output, XLEN bits: writeback value.
REQ-013 Port oDONE, output, 1 bit: one-cycle completion pulse.
REQ-014 Port oILLEGAL, output, 1 bit: reserved or unsupported encoding, valid with oDONE.
REQ-015 Port oMISALIGNED, output, 1 bit: misaligned load address, valid with oDONE.
REQ-016 Port oRAM_CE, output, 1 bit: RAM chip enable.
REQ-017 Port oRAM_RD, output, 1 bit: RAM read request.
REQ-018 Port oRAM_ADDR, output, RAM_AW bits: RAM word address.
REQ-019 Port iRAM_DATA, input, 32 bits: RAM read data.
REQ-020 Port iRAM_ACK, input, 1 bit: iRAM_DATA is valid this cycle.

Function
REQ-021 The state machine SHALL have states IDLE, MEM_WAIT and DONE, and oREADY SHALL be high only in IDLE.
REQ-022 oRS1 SHALL be 5'd2 for c.lwsp (iIR[1:0]=10, iIR[15:13]=010); otherwise it SHALL be iIR[11:7].
REQ-023 On a transfer, the block SHALL register oRD=iIR[11:7] and decode using imm6={iIR[12],iIR[6:2]}, sign-extended to XLEN where signed.
REQ-024 c.li (01/010) SHALL write sext(imm6); when rd=0 the instruction is a hint and oRD_WE SHALL be 0.
REQ-025 c.addi (01/000) SHALL write iRS1+sext(imm6); when rd=0 or imm6=0 (nop/hint) oRD_WE SHALL be 0.
REQ-026 c.lui (01/011, rd not 0 and not 2) SHALL write sext({imm6,12'h0}); imm6=0 SHALL raise oILLEGAL; rd=0 SHALL be a hint with oRD_WE=0.
REQ-027 c.addi16sp (01/011, rd=2) SHALL write iRS1+sext({iIR[12],iIR[4:3],iIR[5],iIR[2],iIR[6],4'b0}); a zero immediate SHALL raise oILLEGAL.
REQ-028 c.slli (10/000) SHALL write iRS1 shifted left by shamt={iIR[12],iIR[6:2]}; when XLEN=32 and iIR[12]=1 it SHALL raise oILLEGAL; rd=0 or shamt=0 SHALL be a hint with oRD_WE=0.
REQ-029 For c.lwsp, the byte address SHALL be iRS1+{iIR[3:2],iIR[12],iIR[6:4],2'b00}.
REQ-030 For c.lwsp, rd=0 SHALL raise oILLEGAL with no RAM access.
REQ-031 For c.lwsp, an address with [1:0] not 00 SHALL raise oMISALIGNED with no RAM access.
REQ-032 For c.lwsp, oRAM_ADDR SHALL be (address>>2) truncated to RAM_AW bits; wrap-around is silent.
REQ-033 Any other encoding, including iIR[1:0]=11, SHALL raise oILLEGAL with oRD_WE=0.
REQ-034 Non-load operations SHALL go IDLE->DONE: the transfer occurs in cycle 0 and oDONE is high in cycle 1.
REQ-035 A legal load SHALL go IDLE->MEM_WAIT, with oRAM_CE, oRAM_RD and oRAM_ADDR held stable from cycle 1 until iRAM_ACK.
REQ-036 The block SHALL capture iRAM_DATA on iRAM_ACK and go to DONE; oDONE SHALL be high the cycle after the ack.
REQ-037 The captured load data SHALL be sign-extended from bit 31 when XLEN=64.
REQ-038 There SHALL be no timeout on iRAM_ACK.
REQ-039 iRAM_ACK outside MEM_WAIT SHALL be ignored.
REQ-040 DONE SHALL last exactly one cycle and then return to IDLE; back-to-back accepts therefore occur every 2 cycles at best.
REQ-041 oRD_DATA SHALL be 0 whenever oRD_WE=0.

Reset
REQ-042 While iRST is high, the block SHALL be in IDLE with oREADY=1 and all other outputs 0.
REQ-043 Reset in MEM_WAIT SHALL drop the RAM request the next cycle and produce no oDONE.
REQ-044 A transfer offered in the same cycle as iRST SHALL be discarded.

Verification
REQ-045 The bench SHALL apply c.li x5,-1 (0x52FD) -> oDONE at cycle 1, oRD=5, oRD_WE=1, oRD_DATA=0xFFFFFFFF.
REQ-046 The bench SHALL apply c.lwsp x8,4(sp) (0x4412) with iRS1=0x40 and an ack 3 cycles after the request -> oRAM_ADDR=0x11 held for 3 cycles, oDONE 1 cycle after the ack, oRD_DATA=iRAM_DATA.
REQ-047 The bench SHALL apply c.addi16sp with imm 16 (0x6141) and iRS1=0x100 -> oRD_DATA=0x110.
REQ-048 The bench SHALL apply c.slli x1,32 (0x1082) with XLEN=32 -> oILLEGAL=1, oRD_WE=0; with XLEN=64 and iRS1=1 -> oRD_DATA=1<<32.
REQ-049 The bench SHALL apply c.lwsp with iRS1=0x42 -> oMISALIGNED=1, oRAM_CE never asserted, oDONE at cycle 1.
REQ-050 The bench SHALL assert iRST in the 2nd MEM_WAIT cycle, then apply a late ack -> no oDONE, oRAM_CE=0, oREADY=1 after reset.
